// File: rtl/sonar_sweep_uc_if.sv
// Control/status bundle between the sonar sweep sequencer and its
// environment (servo, distance unit, serial unit).
interface sonar_sweep_uc_if #(
  parameter int POS_W = 3
);
  logic             ligar;
  logic             modo;
  logic             medida_pronto;
  logic             envio_pronto;
  logic [POS_W-1:0] posicao;
  logic             medir;
  logic             transmitir;
  logic             erro_medida;
  logic             pronto;
  logic [3:0]       db_estado;

  modport master (
    output ligar, modo, medida_pronto, envio_pronto,
    input  posicao, medir, transmitir, erro_medida, pronto, db_estado
  );

  modport slave (
    input  ligar, modo, medida_pronto, envio_pronto,
    output posicao, medir, transmitir, erro_medida, pronto, db_estado
  );
endinterface

// File: rtl/sonar_sweep_uc.sv
// Sonar sweep sequencer: steps a servo across N_POS positions, triggering a
// measurement and a transmission at each, in single or back-and-forth mode.
module sonar_sweep_uc #(
  parameter int N_POS          = 8,
  parameter int POS_W          = 3,
  parameter int SETTLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 500,
  parameter int WAIT_CYCLES    = 200,
  parameter int MAX_RETRY      = 2,
  parameter int TIMER_W        = 32
) (
  input logic             clock_i,
  input logic             reset_i,
  sonar_sweep_uc_if.slave bus
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  localparam logic [POS_W-1:0] LAST = POS_W'(N_POS - 1);

  typedef enum logic [3:0] {
    INICIAL             = 4'h0,
    POSICIONA           = 4'h1,
    FAZ_MEDIDA          = 4'h2,
    AGUARDA_MEDIDA      = 4'h3,
    FAZ_TRANSMISSAO     = 4'h4,
    AGUARDA_TRANSMISSAO = 4'h5,
    AGUARDA_TEMPO       = 4'h6,
    PROXIMA             = 4'h7,
    FIM                 = 4'hF
  } state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic                 dir_dn_q, dir_dn_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 erro_q, erro_d;
  logic                 modo_q, modo_d;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= INICIAL;
      timer_q  <= '0;
      pos_q    <= '0;
      dir_dn_q <= 1'b0;
      retry_q  <= '0;
      erro_q   <= 1'b0;
      modo_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      pos_q    <= pos_d;
      dir_dn_q <= dir_dn_d;
      retry_q  <= retry_d;
      erro_q   <= erro_d;
      modo_q   <= modo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 1'b1;
    pos_d    = pos_q;
    dir_dn_d = dir_dn_q;
    retry_d  = retry_q;
    erro_d   = erro_q;
    modo_d   = modo_q;
    case (state_q)
      INICIAL: if (bus.ligar) begin
        state_d = POSICIONA;
        modo_d  = bus.modo;
      end
      POSICIONA:
        if (timer_q == TIMER_W'(SETTLE_CYCLES - 1)) state_d = FAZ_MEDIDA;
      FAZ_MEDIDA: state_d = AGUARDA_MEDIDA;
      // a completion landing in the timeout cycle is still a good measurement
      AGUARDA_MEDIDA:
        if (bus.medida_pronto) state_d = FAZ_TRANSMISSAO;
        else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = FAZ_MEDIDA;
          end else begin
            erro_d  = 1'b1;
            state_d = FAZ_TRANSMISSAO;
          end
        end
      FAZ_TRANSMISSAO: state_d = AGUARDA_TRANSMISSAO;
      AGUARDA_TRANSMISSAO: if (bus.envio_pronto) state_d = AGUARDA_TEMPO;
      AGUARDA_TEMPO:
        if (timer_q == TIMER_W'(WAIT_CYCLES - 1)) state_d = PROXIMA;
      PROXIMA: begin
        erro_d  = 1'b0;
        retry_d = '0;
        if (!modo_q && pos_q == LAST) state_d = FIM;
        else begin
          state_d = POSICIONA;
          if (!dir_dn_q) begin
            if (pos_q == LAST) begin
              dir_dn_d = 1'b1;
              pos_d    = pos_q - 1'b1;
            end else pos_d = pos_q + 1'b1;
          end else begin
            if (pos_q == '0) begin
              dir_dn_d = 1'b0;
              pos_d    = pos_q + 1'b1;
            end else pos_d = pos_q - 1'b1;
          end
        end
      end
      FIM:     state_d = INICIAL;
      default: state_d = INICIAL;
    endcase
    if (!bus.ligar) state_d = INICIAL;
    // each timed state starts counting from zero on entry
    if (state_d != state_q) timer_d = '0;
    if (state_d == INICIAL) begin
      timer_d  = '0;
      pos_d    = '0;
      dir_dn_d = 1'b0;
      retry_d  = '0;
      erro_d   = 1'b0;
    end
  end

  assign bus.posicao     = pos_q;
  assign bus.medir       = (state_q == FAZ_MEDIDA);
  assign bus.transmitir  = (state_q == FAZ_TRANSMISSAO);
  assign bus.pronto      = (state_q == FIM);
  assign bus.erro_medida = erro_q;
  assign bus.db_estado   = state_q;

endmodule

// File: tb/tb_sonar_sweep_uc.sv
// Directed bench for sonar_sweep_uc: N_POS=4, SETTLE=3, TIMEOUT=5, WAIT=2,
// MAX_RETRY=2, with an in-loop responder for the distance and serial units.
module tb_sonar_sweep_uc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sonar_sweep_uc_if #(.POS_W(2)) ifc();

  sonar_sweep_uc #(
    .N_POS(4), .POS_W(2), .SETTLE_CYCLES(3), .TIMEOUT_CYCLES(5),
    .WAIT_CYCLES(2), .MAX_RETRY(2), .TIMER_W(8)
  ) dut (
    .clock_i(clk),
    .reset_i(rst),
    .bus    (ifc)
  );

  int total = 0, bad = 0, cyc = 0;
  int n_med, n_tx, n_pr, resp_med;
  int pos_log[$], pos_cyc[$], med_cyc[$], tx_cyc[$];
  logic erro_at_tx;
  logic [3:0] prev_st;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // one clock; log outputs just after the edge, then answer like the peripherals
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
    if (ifc.medir) begin n_med++; med_cyc.push_back(cyc); end
    if (ifc.transmitir) begin n_tx++; tx_cyc.push_back(cyc); erro_at_tx = ifc.erro_medida; end
    if (ifc.pronto) n_pr++;
    if (ifc.db_estado == 4'd1 && prev_st != 4'd1) begin
      pos_log.push_back(int'(ifc.posicao));
      pos_cyc.push_back(cyc);
    end
    prev_st = ifc.db_estado;
    ifc.medida_pronto = (ifc.db_estado == 4'd3) &&
      (resp_med == 1 || (resp_med == 2 && med_cyc.size() > 0 && cyc - med_cyc[$] == 5));
    ifc.envio_pronto = (ifc.db_estado == 4'd5);
  endtask

  task automatic clr_log;
    n_med = 0; n_tx = 0; n_pr = 0; erro_at_tx = 1'b0; prev_st = 4'd0;
    pos_log.delete(); pos_cyc.delete(); med_cyc.delete(); tx_cyc.delete();
  endtask

  task automatic do_reset;
    rst = 1'b1;
    ifc.ligar = 1'b0;
    tick();
    rst = 1'b0;
    clr_log();
  endtask

  initial begin
    rst = 1'b1;
    ifc.ligar = 1'b1;
    ifc.modo = 1'b0;
    ifc.medida_pronto = 1'b0;
    ifc.envio_pronto = 1'b0;
    resp_med = 1;
    clr_log();

    // reset wins over ligar
    tick(); tick();
    chk("rst_state", ifc.db_estado, 0);
    chk("rst_pos", ifc.posicao, 0);
    chk("rst_pulses", {ifc.medir, ifc.transmitir, ifc.pronto}, 0);
    chk("rst_erro", ifc.erro_medida, 0);

    // single sweep
    do_reset();
    ifc.modo = 1'b0; resp_med = 1; ifc.ligar = 1'b1;
    for (int i = 0; i < 300 && n_pr == 0; i++) tick();
    chk("single_npos", pos_log.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("single_pos%0d", i), pos_log[i], i);
    chk("single_medir", n_med, 4);
    chk("single_tx", n_tx, 4);
    chk("settle_len", med_cyc[0] - pos_cyc[0], 3);
    chk("tx_to_next_pos", pos_cyc[1] - tx_cyc[0], 5);
    ifc.ligar = 1'b0;
    tick();
    chk("single_end_state", ifc.db_estado, 0);
    chk("single_end_pos", ifc.posicao, 0);
    tick(); tick();
    chk("single_pronto", n_pr, 1);

    // continuous sweep
    do_reset();
    ifc.modo = 1'b1; resp_med = 1; ifc.ligar = 1'b1;
    for (int i = 0; i < 400 && pos_log.size() < 8; i++) tick();
    chk("cont_npos", pos_log.size(), 8);
    begin
      int exp_seq[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
      for (int i = 0; i < 8; i++) chk($sformatf("cont_pos%0d", i), pos_log[i], exp_seq[i]);
    end
    chk("cont_pronto", n_pr, 0);

    // timeout with retries
    do_reset();
    ifc.modo = 1'b0; resp_med = 0; ifc.ligar = 1'b1;
    for (int i = 0; i < 200 && n_tx == 0; i++) tick();
    chk("to_medir", n_med, 3);
    if (n_med >= 3 && n_tx >= 1) begin
      chk("to_gap1", med_cyc[1] - med_cyc[0], 6);
      chk("to_gap2", med_cyc[2] - med_cyc[1], 6);
      chk("to_tx_gap", tx_cyc[0] - med_cyc[2], 6);
    end
    chk("to_erro_at_tx", erro_at_tx, 1);
    resp_med = 1;
    for (int i = 0; i < 100 && pos_log.size() < 2; i++) tick();
    chk("to_next_pos", ifc.posicao, 1);
    chk("to_erro_clr", ifc.erro_medida, 0);

    // medida_pronto in the timeout cycle
    do_reset();
    ifc.modo = 1'b0; resp_med = 2; ifc.ligar = 1'b1;
    for (int i = 0; i < 200 && n_tx == 0; i++) tick();
    chk("coin_medir", n_med, 1);
    chk("coin_erro", erro_at_tx, 0);
    if (n_tx >= 1 && n_med >= 1) chk("coin_tx_gap", tx_cyc[0] - med_cyc[0], 6);

    // abort in AGUARDA_TRANSMISSAO at posicao 2
    do_reset();
    ifc.modo = 1'b0; resp_med = 1; ifc.ligar = 1'b1;
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
        tick();
        hit = (ifc.db_estado == 4'd5 && ifc.posicao == 2'd2);
      end
      chk("abort_reached", hit, 1);
    end
    ifc.ligar = 1'b0;
    tick();
    chk("abort_state", ifc.db_estado, 0);
    chk("abort_pos", ifc.posicao, 0);
    chk("abort_pulses", {ifc.medir, ifc.transmitir, ifc.pronto}, 0);

    // reset mid-sweep while heading down
    do_reset();
    ifc.modo = 1'b1; resp_med = 1; ifc.ligar = 1'b1;
    for (int i = 0; i < 300 && pos_log.size() < 5; i++) tick();
    chk("mid_pos_before", ifc.posicao, 2);
    rst = 1'b1;
    tick();
    chk("mid_rst_state", ifc.db_estado, 0);
    chk("mid_rst_pos", ifc.posicao, 0);
    rst = 1'b0;
    clr_log();
    for (int i = 0; i < 200 && pos_log.size() < 3; i++) tick();
    chk("mid_npos", pos_log.size(), 3);
    for (int i = 0; i < 3 && i < pos_log.size(); i++)
      chk($sformatf("mid_pos%0d", i), pos_log[i], i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
